// File: rtl/chip_bridge_vc_rcv.sv
// Receive side of the chip bridge virtual-channel link.
// Reassembles 64-bit flits from pairs of 32-bit words for three NoC channels.
// Each channel buffers its flits in a first-word-fall-through FIFO.
// A one-cycle credit pulse is returned for every flit the consumer pops.
module chip_bridge_vc_rcv #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PTR_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic [1:0]  channel_in,
  output logic [2:0]  credit_out,
  output logic [63:0] bout_data_1,
  output logic [63:0] bout_data_2,
  output logic [63:0] bout_data_3,
  output logic        bout_val_1,
  output logic        bout_val_2,
  output logic        bout_val_3,
  input  logic        bout_rdy_1,
  input  logic        bout_rdy_2,
  input  logic        bout_rdy_3,
  output logic [2:0]  overflow_err
);

  localparam logic [PTR_W:0] PtrOne = {{PTR_W{1'b0}}, 1'b1};

  logic [31:0]    r_half   [3];
  logic [2:0]     r_phase;
  logic [PTR_W:0] r_wr_ptr [3];
  logic [PTR_W:0] r_rd_ptr [3];
  logic [63:0]    r_mem    [3][FIFO_DEPTH];
  logic [2:0]     r_credit;
  logic [2:0]     r_ovf;

  logic [2:0]     w_rdy;
  logic [2:0]     w_hit;
  logic [2:0]     w_push;
  logic [2:0]     w_pop;
  logic [2:0]     w_full;
  logic [2:0]     w_empty;
  logic [2:0]     w_accept;
  logic [63:0]    w_head   [3];

  assign w_rdy = {bout_rdy_3, bout_rdy_2, bout_rdy_1};

  // Per-channel decode of the incoming word and FIFO status.
  always_comb begin
    w_hit    = '0;
    w_push   = '0;
    w_pop    = '0;
    w_full   = '0;
    w_empty  = '0;
    w_accept = '0;
    for (int c = 0; c < 3; c++) begin
      w_head[c]   = '0;
      w_hit[c]    = (channel_in == 2'(c + 1));
      w_push[c]   = w_hit[c] & r_phase[c];
      w_empty[c]  = (r_wr_ptr[c] == r_rd_ptr[c]);
      w_full[c]   = (r_wr_ptr[c][PTR_W] != r_rd_ptr[c][PTR_W]) &&
                    (r_wr_ptr[c][PTR_W-1:0] == r_rd_ptr[c][PTR_W-1:0]);
      w_pop[c]    = ~w_empty[c] & w_rdy[c];
      // A pop in the same cycle frees the slot, so a push at full is still accepted.
      w_accept[c] = w_push[c] & (~w_full[c] | w_pop[c]);
      if (!w_empty[c]) begin
        w_head[c] = r_mem[c][r_rd_ptr[c][PTR_W-1:0]];
      end
    end
  end

  // Phase, half registers, pointers, credits and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase  <= '0;
      r_credit <= '0;
      r_ovf    <= '0;
      for (int c = 0; c < 3; c++) begin
        r_half[c]   <= '0;
        r_wr_ptr[c] <= '0;
        r_rd_ptr[c] <= '0;
      end
    end else begin
      r_credit <= w_pop;
      for (int c = 0; c < 3; c++) begin
        if (w_hit[c]) begin
          r_phase[c] <= ~r_phase[c];
        end
        if (w_hit[c] && !r_phase[c]) begin
          r_half[c] <= data_in;
        end
        if (w_accept[c]) begin
          r_wr_ptr[c] <= r_wr_ptr[c] + PtrOne;
        end
        if (w_pop[c]) begin
          r_rd_ptr[c] <= r_rd_ptr[c] + PtrOne;
        end
        // Dropped flit: FIFO untouched, phase still returns to low half above.
        if (w_push[c] && !w_accept[c]) begin
          r_ovf[c] <= 1'b1;
        end
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (!rst && w_accept[c]) begin
        r_mem[c][r_wr_ptr[c][PTR_W-1:0]] <= {data_in, r_half[c]};
      end
    end
  end

  assign credit_out   = r_credit;
  assign overflow_err = r_ovf;
  assign bout_val_1   = ~w_empty[0];
  assign bout_val_2   = ~w_empty[1];
  assign bout_val_3   = ~w_empty[2];
  assign bout_data_1  = w_head[0];
  assign bout_data_2  = w_head[1];
  assign bout_data_3  = w_head[2];

endmodule

// File: tb/tb_chip_bridge_vc_rcv.sv
// Self-checking bench for chip_bridge_vc_rcv: a cycle-level reference model
// with per-channel scoreboard queues, a directed vector table and corner sequences.
module tb_chip_bridge_vc_rcv;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PTRW  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [1:0]  channel_in;
  logic [2:0]  credit_out;
  logic [63:0] bout_data_1, bout_data_2, bout_data_3;
  logic        bout_val_1, bout_val_2, bout_val_3;
  logic        bout_rdy_1, bout_rdy_2, bout_rdy_3;
  logic [2:0]  overflow_err;

  always #5 clk = ~clk;

  chip_bridge_vc_rcv #(
    .FIFO_DEPTH(DEPTH),
    .PTR_W     (PTRW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .channel_in  (channel_in),
    .credit_out  (credit_out),
    .bout_data_1 (bout_data_1),
    .bout_data_2 (bout_data_2),
    .bout_data_3 (bout_data_3),
    .bout_val_1  (bout_val_1),
    .bout_val_2  (bout_val_2),
    .bout_val_3  (bout_val_3),
    .bout_rdy_1  (bout_rdy_1),
    .bout_rdy_2  (bout_rdy_2),
    .bout_rdy_3  (bout_rdy_3),
    .overflow_err(overflow_err)
  );

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] d;
    logic [2:0]  rdy;
    logic [2:0]  exp_val;
    logic [2:0]  exp_cred;
  } vec_t;

  vec_t        vecs [12];
  int          checks   = 0;
  int          failures = 0;
  bit          mon_en   = 1'b0;

  // Reference model state.
  logic [63:0] q [3][$];
  logic [2:0]  m_phase;
  logic [31:0] m_half [3];
  logic [2:0]  exp_err;
  logic [2:0]  exp_cred;
  int          cred_cnt [3];
  int          pop_cnt  [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model, then advance the model by one cycle.
  always @(negedge clk) begin
    logic [2:0]  val;
    logic [2:0]  rdy;
    logic [63:0] dout [3];
    logic        pop;
    int          sz;
    val     = {bout_val_3, bout_val_2, bout_val_1};
    rdy     = {bout_rdy_3, bout_rdy_2, bout_rdy_1};
    dout[0] = bout_data_1;
    dout[1] = bout_data_2;
    dout[2] = bout_data_3;
    if (mon_en) begin
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("val_ch%0d", c + 1), 64'(val[c]), 64'(q[c].size() != 0));
        if (val[c] && q[c].size() != 0) begin
          chk($sformatf("data_ch%0d", c + 1), dout[c], q[c][0]);
        end
        chk($sformatf("credit_ch%0d", c + 1), 64'(credit_out[c]), 64'(exp_cred[c]));
        if (credit_out[c] === 1'b1) cred_cnt[c]++;
      end
      chk("overflow_err", 64'(overflow_err), 64'(exp_err));
    end
    if (rst) begin
      m_phase  = '0;
      exp_err  = '0;
      exp_cred = '0;
      for (int c = 0; c < 3; c++) begin
        q[c].delete();
        m_half[c] = '0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        sz  = q[c].size();
        pop = (sz != 0) && rdy[c];
        exp_cred[c] = pop;
        if (pop) begin
          void'(q[c].pop_front());
          pop_cnt[c]++;
        end
        if (channel_in == 2'(c + 1)) begin
          if (!m_phase[c]) begin
            m_half[c]  = data_in;
            m_phase[c] = 1'b1;
          end else begin
            m_phase[c] = 1'b0;
            if (sz == int'(DEPTH) && !pop) exp_err[c] = 1'b1;
            else q[c].push_back({data_in, m_half[c]});
          end
        end
      end
    end
  end

  task automatic drive(input logic [1:0] ch, input logic [31:0] d);
    @(posedge clk);
    #1;
    channel_in = ch;
    data_in    = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'd0, 32'h0);
  endtask

  task automatic drain(input int c, input string name);
    int n;
    n = 0;
    while (q[c].size() != 0 && n < 200) begin
      drive(2'd0, 32'h0);
      n++;
    end
    chk({name, "_drain_timeout"}, 64'(n < 200), 64'd1);
    idle(2);
  endtask

  initial begin
    int c0, p0;
    for (int c = 0; c < 3; c++) begin
      cred_cnt[c] = 0;
      pop_cnt[c]  = 0;
    end
    vecs[0]  = {2'd1, 32'h1111_2222, 3'b111, 3'b000, 3'b000};
    vecs[1]  = {2'd1, 32'h3333_4444, 3'b111, 3'b000, 3'b000};
    vecs[2]  = {2'd0, 32'h0,         3'b111, 3'b001, 3'b000};
    vecs[3]  = {2'd0, 32'h0,         3'b111, 3'b000, 3'b001};
    vecs[4]  = {2'd0, 32'h0,         3'b111, 3'b000, 3'b000};
    vecs[5]  = {2'd1, 32'hAAAA_0001, 3'b111, 3'b000, 3'b000};
    vecs[6]  = {2'd2, 32'hBBBB_0002, 3'b111, 3'b000, 3'b000};
    vecs[7]  = {2'd1, 32'hCCCC_0003, 3'b111, 3'b000, 3'b000};
    vecs[8]  = {2'd2, 32'hDDDD_0004, 3'b111, 3'b001, 3'b000};
    vecs[9]  = {2'd0, 32'h0,         3'b111, 3'b010, 3'b001};
    vecs[10] = {2'd0, 32'h0,         3'b111, 3'b000, 3'b010};
    vecs[11] = {2'd0, 32'h0,         3'b111, 3'b000, 3'b000};

    rst        = 1'b1;
    data_in    = '0;
    channel_in = '0;
    bout_rdy_1 = 1'b1;
    bout_rdy_2 = 1'b1;
    bout_rdy_3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_data1", bout_data_1, 64'h0);
    chk("reset_data2", bout_data_2, 64'h0);
    chk("reset_data3", bout_data_3, 64'h0);
    idle(2);

    // Single flit then ch1/ch2 interleave.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      channel_in = vecs[i].ch;
      data_in    = vecs[i].d;
      {bout_rdy_3, bout_rdy_2, bout_rdy_1} = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_val", i), 64'({bout_val_3, bout_val_2, bout_val_1}),
          64'(vecs[i].exp_val));
      chk($sformatf("vec%0d_credit", i), 64'(credit_out), 64'(vecs[i].exp_cred));
      if (i == 2) chk("vec2_data1", bout_data_1, 64'h3333_4444_1111_2222);
      if (i == 9) chk("vec9_data2", bout_data_2, 64'hDDDD_0004_BBBB_0002);
    end

    // Backpressure on ch2: one flit more than the FIFO holds.
    bout_rdy_2 = 1'b0;
    c0 = cred_cnt[1];
    for (int i = 0; i <= int'(DEPTH); i++) begin
      drive(2'd2, 32'h2000_0000 + i);
      drive(2'd2, 32'h2100_0000 + i);
    end
    idle(2);
    chk("bp_val2_held", 64'(bout_val_2), 64'd1);
    chk("bp_overflow", 64'(overflow_err), 64'(3'b010));
    chk("bp_head", bout_data_2, {32'h2100_0000, 32'h2000_0000});
    bout_rdy_2 = 1'b1;
    drain(1, "bp");
    chk("bp_credits", 64'(cred_cnt[1] - c0), 64'(DEPTH));

    // ch3 full while the completing high half coincides with a pop.
    bout_rdy_3 = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      drive(2'd3, 32'h3000_0000 + i);
      drive(2'd3, 32'h3100_0000 + i);
    end
    drive(2'd3, 32'h3000_00FF);
    drive(2'd3, 32'h3100_00FF);
    bout_rdy_3 = 1'b1;
    idle(1);
    chk("fullpop_no_ovf", 64'(overflow_err[2]), 64'd0);
    drain(2, "fullpop");

    // Reset in the middle of a ch1 flit; word during reset is ignored.
    drive(2'd1, 32'hAAAA_AAAA);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    channel_in = 2'd1;
    data_in    = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    channel_in = 2'd0;
    chk("rst_val", 64'({bout_val_3, bout_val_2, bout_val_1}), 64'd0);
    chk("rst_credit", 64'(credit_out), 64'd0);
    chk("rst_ovf", 64'(overflow_err), 64'd0);
    chk("rst_data", bout_data_1 | bout_data_2 | bout_data_3, 64'h0);
    drive(2'd1, 32'h0000_0001);
    drive(2'd1, 32'h0000_0002);
    bout_rdy_1 = 1'b0;
    idle(1);
    @(negedge clk);
    chk("rst_flit", bout_data_1, 64'h0000_0002_0000_0001);
    bout_rdy_1 = 1'b1;
    drain(0, "rst");

    // Pointer wrap on ch3 with random ready, capped so the FIFO never fills.
    c0 = cred_cnt[2];
    p0 = pop_cnt[2];
    for (int i = 0; i < 3 * int'(DEPTH); i++) begin
      for (int h = 0; h < 2; h++) begin
        drive(2'd3, 32'h5000_0000 + (i << 4) + h);
        bout_rdy_3 = (q[2].size() >= int'(DEPTH) - 1) ? 1'b1 : 1'($urandom_range(0, 1));
      end
    end
    bout_rdy_3 = 1'b1;
    drain(2, "wrap");
    chk("wrap_pops", 64'(pop_cnt[2] - p0), 64'(3 * DEPTH));
    chk("wrap_credits", 64'(cred_cnt[2] - c0), 64'(3 * DEPTH));
    chk("wrap_no_ovf", 64'(overflow_err[2]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
